// File: rtl/split_ctrl_pkg.sv
// Shared types and defaults for the split sweep controller.
// Holds the FSM state encoding and the default parameter values.
package split_ctrl_pkg;

   localparam int DEF_WIDTH       = 2;
   localparam int DEF_HOLD_CYCLES = 5;
   localparam int DEF_SIG_W       = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/split_sweep_ctrl_if.sv
// Stimulus/response bundle between the sweep controller and its environment.
// The master side drives operands and status; the slave side drives start and o.
interface split_sweep_ctrl_if
   import split_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SIG_W = DEF_SIG_W
);

   logic             start;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [WIDTH-1:0] o_in;
   logic             busy;
   logic             done;
   logic [SIG_W-1:0] signature;

   modport master (
      input  start,
      input  o_in,
      output a_out,
      output b_out,
      output busy,
      output done,
      output signature
   );

   modport slave (
      output start,
      output o_in,
      input  a_out,
      input  b_out,
      input  busy,
      input  done,
      input  signature
   );

endinterface

// File: rtl/split_dwell_counter.sv
// Per-vector dwell counter: counts 0..HOLD_CYCLES-1 and wraps.
// last marks the sample cycle of the current vector.
module split_dwell_counter #(
   parameter int HOLD_CYCLES = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] count;

   assign last = (count == LAST_CNT);

   // Clear wins over counting; wrap to zero on the sample cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         if (last) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/split_sweep_ctrl.sv
// Self-driving sweep of every {a, b} vector into split, holding each for
// a fixed dwell and folding each sampled o into a rotate-XOR signature.
module split_sweep_ctrl
   import split_ctrl_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int SIG_W       = DEF_SIG_W
) (
   input  logic                  clk,
   input  logic                  reset,
   split_sweep_ctrl_if.master    bus
);

   localparam int OW = 2 * WIDTH;

   state_t           state;
   logic [OW-1:0]    ops;
   logic [SIG_W-1:0] sig;
   logic [SIG_W-1:0] sig_next;
   logic             busy_q;
   logic             done_q;
   logic             cnt_clear;
   logic             cnt_en;
   logic             last;

   assign cnt_clear = (state == S_IDLE) && bus.start;
   assign cnt_en    = (state == S_RUN);

   assign sig_next = {sig[SIG_W-2:0], sig[SIG_W-1]}
                   ^ {{(SIG_W - WIDTH){1'b0}}, bus.o_in};

   split_dwell_counter #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_dwell (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .last   (last)
   );

   // Sweep FSM with registered operand, signature and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         ops    <= '0;
         sig    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state  <= S_RUN;
                  ops    <= '0;
                  sig    <= '0;
                  busy_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (last) begin
                  sig <= sig_next;
                  ops <= ops + OW'(1);
                  if (&ops) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_out     = ops[OW-1:WIDTH];
   assign bus.b_out     = ops[WIDTH-1:0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.signature = sig;

endmodule

// File: tb/tb_split_sweep_ctrl.sv
// Bench for split_sweep_ctrl: a HOLD=5 and a HOLD=1 instance against a
// reference model of the sweep order, dwell timing and signature.
module tb_split_sweep_ctrl;

   localparam int N  = 16;
   localparam int H0 = 5;
   localparam int H1 = 1;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   logic [1:0] lut0 [16];
   logic [1:0] lut1 [16];
   logic [7:0] ones_tab [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                8'h1F, 8'h3F, 8'h7F, 8'hFF};

   split_sweep_ctrl_if #(.WIDTH(2), .SIG_W(8)) bus0 ();
   split_sweep_ctrl_if #(.WIDTH(2), .SIG_W(8)) bus1 ();

   assign bus0.o_in = lut0[{bus0.a_out, bus0.b_out}];
   assign bus1.o_in = lut1[{bus1.a_out, bus1.b_out}];

   split_sweep_ctrl #(.WIDTH(2), .HOLD_CYCLES(H0), .SIG_W(8)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   split_sweep_ctrl #(.WIDTH(2), .HOLD_CYCLES(H1), .SIG_W(8)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mstep(logic [7:0] s, logic [1:0] o);
      int v;
      v = (int'(s) * 2) % 256 + int'(s) / 128;
      return 8'(v) ^ {6'b0, o};
   endfunction

   task automatic idle_chk(input string tag, input logic [7:0] sig0);
      chk({tag, "_busy0"}, 32'(bus0.busy), 0);
      chk({tag, "_done0"}, 32'(bus0.done), 0);
      chk({tag, "_a0"}, 32'(bus0.a_out), 0);
      chk({tag, "_b0"}, 32'(bus0.b_out), 0);
      chk({tag, "_sig0"}, 32'(bus0.signature), 32'(sig0));
   endtask

   task automatic rand_lut0();
      for (int i = 0; i < 16; i++) lut0[i] = 2'($urandom_range(3, 0));
   endtask

   // One full sweep on the HOLD=5 instance, checked cycle by cycle.
   task automatic sweep0(input bit pulses, input bit ones);
      logic [7:0] es [N+1];
      int pr;
      int k;
      es[0] = 8'h00;
      for (int i = 0; i < N; i++) es[i+1] = mstep(es[i], lut0[i]);
      pr = $urandom_range(N * H0, 1);
      bus0.start = 1'b1;
      step();
      bus0.start = 1'b0;
      for (int t = 1; t <= N * H0; t++) begin
         k = (t - 1) / H0;
         chk("run_busy", 32'(bus0.busy), 1);
         chk("run_done", 32'(bus0.done), 0);
         chk("run_a", 32'(bus0.a_out), 32'(k / 4));
         chk("run_b", 32'(bus0.b_out), 32'(k % 4));
         chk("run_sig", 32'(bus0.signature), 32'(es[k]));
         if (ones && (t % H0 == 1) && k >= 1 && k <= 8)
            chk("ones_sig", 32'(bus0.signature), 32'(ones_tab[k-1]));
         bus0.start = pulses && (t == pr);
         step();
      end
      bus0.start = 1'b0;
      chk("fin_done", 32'(bus0.done), 1);
      chk("fin_busy", 32'(bus0.busy), 0);
      chk("fin_a", 32'(bus0.a_out), 0);
      chk("fin_b", 32'(bus0.b_out), 0);
      chk("fin_sig", 32'(bus0.signature), 32'(es[N]));
      if (ones) chk("ones_final", 32'(bus0.signature), 0);
      bus0.start = pulses;
      step();
      bus0.start = 1'b0;
      idle_chk("post1", es[N]);
      step();
      idle_chk("post2", es[N]);
   endtask

   initial begin
      logic [7:0] es1 [N+1];
      logic [7:0] er [N+1];
      int p;
      int k;
      n_chk      = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         lut0[i] = 2'b00;
         lut1[i] = 2'b00;
      end
      step();
      step();
      reset = 1'b0;

      for (int c = 0; c < 10; c++) begin
         step();
         idle_chk("idle", 8'h00);
         chk("idle_busy1", 32'(bus1.busy), 0);
         chk("idle_done1", 32'(bus1.done), 0);
         chk("idle_sig1", 32'(bus1.signature), 0);
      end

      sweep0(1'b0, 1'b0);

      for (int i = 0; i < 16; i++) lut0[i] = 2'b01;
      sweep0(1'b0, 1'b1);

      rand_lut0();
      sweep0(1'b1, 1'b0);
      rand_lut0();
      sweep0(1'b1, 1'b0);
      rand_lut0();
      sweep0(1'b0, 1'b0);

      for (int i = 0; i < 16; i++) lut1[i] = 2'($urandom_range(3, 0));
      es1[0] = 8'h00;
      for (int i = 0; i < N; i++) es1[i+1] = mstep(es1[i], lut1[i]);
      bus1.start = 1'b1;
      step();
      for (int t = 1; t <= 36; t++) begin
         p = t % (N * H1 + 2);
         if (p >= 1 && p <= N) begin
            chk("h1_busy", 32'(bus1.busy), 1);
            chk("h1_done", 32'(bus1.done), 0);
            chk("h1_a", 32'(bus1.a_out), 32'((p - 1) / 4));
            chk("h1_b", 32'(bus1.b_out), 32'((p - 1) % 4));
            chk("h1_sig", 32'(bus1.signature), 32'(es1[p-1]));
         end else if (p == N + 1) begin
            chk("h1_fin_done", 32'(bus1.done), 1);
            chk("h1_fin_busy", 32'(bus1.busy), 0);
            chk("h1_fin_sig", 32'(bus1.signature), 32'(es1[N]));
         end else begin
            chk("h1_gap_busy", 32'(bus1.busy), 0);
            chk("h1_gap_done", 32'(bus1.done), 0);
            chk("h1_gap_sig", 32'(bus1.signature), 32'(es1[N]));
         end
         if (t >= 35) bus1.start = 1'b0;
         step();
      end
      chk("h1_stop_busy", 32'(bus1.busy), 0);
      chk("h1_stop_done", 32'(bus1.done), 0);

      rand_lut0();
      lut0[0] = 2'b11;
      er[0] = 8'h00;
      for (int i = 0; i < N; i++) er[i+1] = mstep(er[i], lut0[i]);
      bus0.start = 1'b1;
      step();
      bus0.start = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         k = (t - 1) / H0;
         chk("pre_busy", 32'(bus0.busy), 1);
         chk("pre_a", 32'(bus0.a_out), 32'(k / 4));
         chk("pre_b", 32'(bus0.b_out), 32'(k % 4));
         chk("pre_sig", 32'(bus0.signature), 32'(er[k]));
         if (t == 40) reset = 1'b1;
         step();
      end
      reset = 1'b0;
      idle_chk("rst", 8'h00);
      for (int c = 0; c < 60; c++) begin
         step();
         idle_chk("rst_idle", 8'h00);
      end

      rand_lut0();
      sweep0(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
